// File: rtl/alu_arbiter.sv
// Round-robin front-end sharing one ALU between two requesters.
// Latches the winning operands, selects the ALU result by opcode and returns it with flags.
module alu_arbiter #(
    parameter int DATA_W = 16,
    parameter int OPC_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPC_W-1:0]  req0_opc,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPC_W-1:0]  req1_opc,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic [DATA_W-1:0] alu_add,
    input  logic [DATA_W-1:0] alu_sub,
    input  logic [DATA_W-1:0] alu_and,
    input  logic [DATA_W-1:0] alu_or,
    input  logic [DATA_W-1:0] alu_xor,
    input  logic [DATA_W-1:0] alu_not,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_neg,
    output logic              rsp_err,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for a request, winner's ready asserted
    // EXEC  | ALU evaluating the latched operands
    // RESP  | response presented until rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [OPC_W-1:0] OPC_ADD = OPC_W'(0);
    localparam logic [OPC_W-1:0] OPC_SUB = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_AND = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_OR  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OPC_XOR = OPC_W'(4);
    localparam logic [OPC_W-1:0] OPC_NOT = OPC_W'(5);

    state_t            state;
    logic              prio;
    logic              id_q;
    logic [OPC_W-1:0]  opc_q;
    logic              grant0;
    logic              grant1;
    logic [DATA_W-1:0] sel;
    logic              sel_err;

    // prio names the requester preferred when both are valid
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (req0_valid && (!req1_valid || !prio))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    always_comb begin
        sel     = '0;
        sel_err = 1'b0;
        case (opc_q)
            OPC_ADD: sel = alu_add;
            OPC_SUB: sel = alu_sub;
            OPC_AND: sel = alu_and;
            OPC_OR:  sel = alu_or;
            OPC_XOR: sel = alu_xor;
            OPC_NOT: sel = alu_not;
            default: sel_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            id_q      <= 1'b0;
            opc_q     <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        id_q    <= grant1;
                        opc_q   <= grant1 ? req1_opc : req0_opc;
                        alu_op1 <= grant1 ? req1_a : req0_a;
                        alu_op2 <= grant1 ? req1_b : req0_b;
                        prio    <= !grant1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= sel;
                    rsp_zero  <= (sel == '0);
                    rsp_neg   <= sel[DATA_W-1];
                    rsp_err   <= sel_err;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural response model checked every cycle,
// plus hand-computed expectations on each directed vector.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_opc, req1_opc;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] alu_op1, alu_op2;
    logic [15:0] alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_not;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_neg, rsp_err, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // reference ALU driven from the registered operands
    assign alu_add = alu_op1 + alu_op2;
    assign alu_sub = alu_op1 - alu_op2;
    assign alu_and = alu_op1 & alu_op2;
    assign alu_or  = alu_op1 | alu_op2;
    assign alu_xor = alu_op1 ^ alu_op2;
    assign alu_not = ~alu_op1;

    alu_arbiter #(.DATA_W(16), .OPC_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opc(req0_opc),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opc(req1_opc),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_add(alu_add), .alu_sub(alu_sub), .alu_and(alu_and),
        .alu_or(alu_or), .alu_xor(alu_xor), .alu_not(alu_not),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
        .rsp_err(rsp_err), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        id;
        logic [15:0] data;
        logic        zero;
        logic        neg;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          phase;      // 0 waiting for request, 1 computing, 2 response offered
    logic        m_prio;
    logic [15:0] m_op1, m_op2;

    function automatic rsp_t model_op(input logic id, input logic [2:0] opc,
                                      input logic [15:0] a, input logic [15:0] b);
        rsp_t r;
        r.id  = id;
        r.err = 1'b0;
        case (opc)
            3'd0: r.data = a + b;
            3'd1: r.data = a - b;
            3'd2: r.data = a & b;
            3'd3: r.data = a | b;
            3'd4: r.data = a ^ b;
            3'd5: r.data = ~a;
            default: begin r.data = 16'h0000; r.err = 1'b1; end
        endcase
        r.zero = (r.data == 16'h0000);
        r.neg  = r.data[15];
        return r;
    endfunction

    initial begin
        phase = 0; m_prio = 1'b0; m_op1 = '0; m_op2 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0; m_prio = 1'b0; m_op1 = '0; m_op2 = '0;
                exp_q.delete();
                chk("rst_ready0", req0_ready, 0);
                chk("rst_ready1", req1_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_op1", alu_op1, 0);
            end else begin
                logic e0, e1;
                e0 = (phase == 0) && req0_valid && (!req1_valid || !m_prio);
                e1 = (phase == 0) && req1_valid && (!req0_valid || m_prio);
                chk("m_ready0", req0_ready, e0);
                chk("m_ready1", req1_ready, e1);
                chk("m_busy", busy, phase != 0);
                chk("m_rsp_valid", rsp_valid, phase == 2);
                chk("m_op1", alu_op1, m_op1);
                chk("m_op2", alu_op2, m_op2);
                if (phase == 2 && exp_q.size() > 0) begin
                    chk("m_rsp_id", rsp_id, exp_q[0].id);
                    chk("m_rsp_data", rsp_data, exp_q[0].data);
                    chk("m_rsp_flags", {rsp_zero, rsp_neg, rsp_err},
                        {exp_q[0].zero, exp_q[0].neg, exp_q[0].err});
                end
                case (phase)
                    0: begin
                        if (e0) begin
                            exp_q.push_back(model_op(1'b0, req0_opc, req0_a, req0_b));
                            m_op1 = req0_a; m_op2 = req0_b; m_prio = 1'b1; phase = 1;
                        end else if (e1) begin
                            exp_q.push_back(model_op(1'b1, req1_opc, req1_a, req1_b));
                            m_op1 = req1_a; m_op2 = req1_b; m_prio = 1'b0; phase = 1;
                        end
                    end
                    1: phase = 2;
                    default: if (rsp_ready) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issue one request, check literal response values; starts and ends at posedge+1.
    task automatic issue(input int r, input logic [2:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_data,
                         input logic ez, input logic en, input logic ee);
        int n;
        if (r == 0) begin req0_opc = opc; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else        begin req1_opc = opc; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        n = 0;
        @(negedge clk);
        while (!(r == 0 ? req0_ready : req1_ready) && n < 20) begin @(negedge clk); n++; end
        chk("issue_grant_timeout", n < 20, 1);
        @(posedge clk); #1;
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("rsp_latency", n, 1);
        chk("lit_id", rsp_id, r[0]);
        chk("lit_data", rsp_data, exp_data);
        chk("lit_zero", rsp_zero, ez);
        chk("lit_neg", rsp_neg, en);
        chk("lit_err", rsp_err, ee);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 0; req0_opc = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_opc = 0; req1_a = 0; req1_b = 0;
        @(negedge clk);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_flags", {rsp_id, rsp_zero, rsp_neg, rsp_err}, 0);
        chk("reset_op2", alu_op2, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD with sign change, SUB zero and wrap, NOT, illegal opcodes
        issue(0, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0);
        issue(0, 3'd1, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0);
        issue(1, 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 0, 1, 0);
        issue(0, 3'd5, 16'h00FF, 16'h1234, 16'hFF00, 0, 1, 0);
        issue(1, 3'd6, 16'h1234, 16'h5678, 16'h0000, 1, 0, 1);
        issue(0, 3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 1);
        issue(1, 3'd3, 16'hA000, 16'h0005, 16'hA005, 0, 1, 0);

        // round-robin from reset
        do_reset();
        req0_opc = 3'd0; req0_a = 16'h0001; req0_b = 16'h0002; req0_valid = 1'b1;
        req1_opc = 3'd4; req1_a = 16'h0F0F; req1_b = 16'h00FF; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
            chk("rr_timeout", n < 20, 1);
            chk("rr_id", rsp_id, i % 2);
            chk("rr_data", rsp_data, (i % 2) ? 16'h0FF0 : 16'h0003);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // only requester 1 valid
        issue(1, 3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 0, 1, 0);
        issue(1, 3'd0, 16'h0010, 16'h0020, 16'h0030, 0, 0, 0);

        // backpressure
        rsp_ready = 1'b0;
        req0_opc = 3'd2; req0_a = 16'h00F0; req0_b = 16'h0FFF; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_opc = 3'd0; req1_a = 16'h0001; req1_b = 16'h0001; req1_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_timeout", n < 20, 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 16'h00F0);
            chk("bp_id", rsp_id, 0);
            chk("bp_readies", {req0_ready, req1_ready}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_valid", rsp_valid, 0);
        chk("bp_after_busy", busy, 0);
        @(posedge clk); #1;

        // reset during EXEC
        req0_opc = 3'd0; req0_a = 16'h1111; req0_b = 16'h2222; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("exec_busy", busy, 1);
        chk("exec_op1", alu_op1, 16'h1111);
        #2 rst = 1'b1;
        #1;
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_op1", alu_op1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        req0_opc = 3'd0; req0_a = 16'h0001; req0_b = 16'h0001; req0_valid = 1'b1;
        req1_opc = 3'd1; req1_a = 16'h0009; req1_b = 16'h0001; req1_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("post_rst_id", rsp_id, 0);
        chk("post_rst_data", rsp_data, 16'h0002);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
